// File: rtl/ccff_chain_loader.sv
// Configuration-chain writer: shifts a sentinel then bitstream words MSB-first into the
// ccff_head -> ccff_tail chain, and checks the sentinel as it emerges at ccff_tail.
module ccff_chain_loader #(
    parameter int unsigned       CHAIN_LEN = 1024,
    parameter int unsigned       WORD_W    = 32,
    parameter int unsigned       SENT_W    = 8,
    parameter logic [SENT_W-1:0] SENTINEL  = 8'hA5,
    parameter int unsigned       CNT_W     = $clog2(CHAIN_LEN + SENT_W + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int unsigned NW   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned WC_W = $clog2(NW + 1);
    localparam int unsigned SC_W = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] K_LAST      = CNT_W'(SENT_W + CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] K_SENT_LAST = CNT_W'(SENT_W - 1);
    localparam logic [CNT_W-1:0] K_CHK       = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {S_IDLE, S_SENT, S_DATA, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [WORD_W-1:0] sh_q, sh_d, hold_q, hold_d;
    logic [SC_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic              hold_vld_q, hold_vld_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              ccff_head_q, ccff_head_d;
    logic              shift_en_q, shift_en_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              take_data;

    // Sentinel bit j, counted from the MSB (the first bit shifted).
    function automatic logic sent_bit(input logic [CNT_W-1:0] j);
        logic b;
        b = 1'b0;
        for (int unsigned i = 0; i < SENT_W; i++) begin
            if (j == CNT_W'(SENT_W - 1 - i)) b = SENTINEL[i];
        end
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sh_d        = sh_q;
        sh_cnt_d    = sh_cnt_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        wcnt_d      = wcnt_q;
        ccff_head_d = ccff_head_q;
        shift_en_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        take_data   = 1'b0;

        if (s_valid && s_ready_q) begin
            hold_d     = s_data;
            hold_vld_d = 1'b1;
            wcnt_d     = wcnt_q + WC_W'(1);
        end

        // k_q is the index of the shift presented this cycle.
        if (shift_en_q) begin
            k_d = k_q + CNT_W'(1);
            if (k_q >= K_CHK && ccff_tail != sent_bit(k_q - K_CHK)) pass_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SENT;
                    k_d         = '0;
                    pass_d      = 1'b1;
                    busy_d      = 1'b1;
                    shift_en_d  = 1'b1;
                    ccff_head_d = SENTINEL[SENT_W-1];
                    sh_cnt_d    = '0;
                    hold_vld_d  = 1'b0;
                    wcnt_d      = '0;
                end
            end
            S_SENT: begin
                if (k_q == K_SENT_LAST) begin
                    state_d   = S_DATA;
                    take_data = 1'b1;
                end else begin
                    shift_en_d  = 1'b1;
                    ccff_head_d = sent_bit(k_d);
                end
            end
            S_DATA: begin
                if (shift_en_q && k_q == K_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    take_data = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Source priority: shift register, then holding register (which already
        // includes a word accepted this cycle, so an empty pipeline has no bubble).
        if (take_data) begin
            if (sh_cnt_q != '0) begin
                shift_en_d  = 1'b1;
                ccff_head_d = sh_q[WORD_W-1];
                sh_d        = sh_q << 1;
                sh_cnt_d    = sh_cnt_q - SC_W'(1);
            end else if (hold_vld_d) begin
                shift_en_d  = 1'b1;
                ccff_head_d = hold_d[WORD_W-1];
                sh_d        = hold_d << 1;
                sh_cnt_d    = SC_W'(WORD_W - 1);
                hold_vld_d  = 1'b0;
            end
        end

        s_ready_d = (state_d == S_SENT || state_d == S_DATA) && !hold_vld_d &&
                    (wcnt_d < WC_W'(NW));
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            sh_q        <= '0;
            sh_cnt_q    <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            wcnt_q      <= '0;
            ccff_head_q <= 1'b0;
            shift_en_q  <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sh_q        <= sh_d;
            sh_cnt_q    <= sh_cnt_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            wcnt_q      <= wcnt_d;
            ccff_head_q <= ccff_head_d;
            shift_en_q  <= shift_en_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign ccff_head     = ccff_head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 40-flop chain model (optionally shortened or stuck).
module tb_ccff_chain_loader;

    localparam int unsigned CHAIN_LEN = 40;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned SENT_W    = 8;

    logic              prog_clk = 1'b0;
    logic              pReset   = 1'b1;
    logic              start    = 1'b0;
    logic [WORD_W-1:0] s_data   = '0;
    logic              s_valid  = 1'b0;
    logic              s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, pass;

    logic [CHAIN_LEN-1:0] chain = '0;
    int tail_mode = 0;
    int en_cnt = 0, stall_cnt = 0, done_cnt = 0, acc_cnt = 0;
    int checks = 0, passed = 0;
    logic [WORD_W-1:0] words [3] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .SENT_W   (SENT_W),
        .SENTINEL (8'hA5)
    ) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .pass         (pass)
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
        en_cnt    <= en_cnt + int'(ccff_shift_en);
        stall_cnt <= stall_cnt + int'(busy && !ccff_shift_en);
        done_cnt  <= done_cnt + int'(done);
        acc_cnt   <= acc_cnt + int'(s_valid && s_ready);
    end

    always_comb begin
        case (tail_mode)
            1:       ccff_tail = chain[CHAIN_LEN-2];
            2:       ccff_tail = 1'b0;
            default: ccff_tail = chain[CHAIN_LEN-1];
        endcase
    end

    // Pulses start and feeds words; optionally withholds word 2 for `stall` starved cycles.
    task automatic drive_load(input int stall, input bit repulse, output bit timed_out);
        int acc0, held, a;
        acc0 = acc_cnt;
        held = 0;
        timed_out = 1'b1;
        @(negedge prog_clk);
        start = 1'b1;
        s_valid = 1'b1;
        s_data = words[0];
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge prog_clk);
            start = repulse && (cyc == 20);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy && !ccff_shift_en) held++;
            a = acc_cnt - acc0;
            if (a == 1 && held < stall) s_valid = 1'b0;
            else begin
                s_valid = 1'b1;
                s_data = words[(a > 2) ? 2 : a];
            end
        end
    endtask

    task automatic test_reset();
        pReset = 1'b1;
        repeat (3) @(negedge prog_clk);
        checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got %b want 0", s_ready); else passed++;
        checks++; if (ccff_head !== 1'b0) $display("FAIL reset_head got %b want 0", ccff_head); else passed++;
        checks++; if (ccff_shift_en !== 1'b0) $display("FAIL reset_shift_en got %b want 0", ccff_shift_en); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else passed++;
        pReset = 1'b0;
        @(negedge prog_clk);
    endtask

    task automatic run_and_check(input string name, input int stall, input bit repulse,
                                 input logic exp_pass, input bit check_chain);
        int en0, st0, d0, a0;
        bit to;
        en0 = en_cnt; st0 = stall_cnt; d0 = done_cnt; a0 = acc_cnt;
        drive_load(stall, repulse, to);
        checks++; if (to) $display("FAIL %s_timeout done never seen", name); else passed++;
        checks++; if (pass !== exp_pass) $display("FAIL %s_pass got %b want %b", name, pass, exp_pass); else passed++;
        @(negedge prog_clk);
        checks++; if (en_cnt - en0 != 48) $display("FAIL %s_shifts got %0d want 48", name, en_cnt - en0); else passed++;
        checks++; if (stall_cnt - st0 != stall) $display("FAIL %s_stalls got %0d want %0d", name, stall_cnt - st0, stall); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt - d0); else passed++;
        checks++; if (acc_cnt - a0 != 2) $display("FAIL %s_words got %0d want 2", name, acc_cnt - a0); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL %s_idle busy=%b done=%b want 0 0", name, busy, done); else passed++;
        checks++; if (pass !== exp_pass) $display("FAIL %s_pass_held got %b want %b", name, pass, exp_pass); else passed++;
        if (check_chain) begin
            checks++;
            if (chain !== 40'hDEADBEEF12) $display("FAIL %s_chain got %h want deadbeef12", name, chain);
            else passed++;
        end
    endtask

    task automatic test_normal();
        run_and_check("normal", 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_stall();
        run_and_check("stall", 5, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_broken_chain();
        tail_mode = 1;
        run_and_check("short_chain", 0, 1'b0, 1'b0, 1'b0);
        tail_mode = 2;
        run_and_check("stuck_tail", 0, 1'b0, 1'b0, 1'b0);
        tail_mode = 0;
    endtask

    task automatic test_reset_mid();
        int en0, n, a0;
        en0 = en_cnt;
        a0 = acc_cnt;
        @(negedge prog_clk);
        start = 1'b1; s_valid = 1'b1; s_data = words[0];
        @(negedge prog_clk);
        start = 1'b0;
        n = 0;
        while (en_cnt - en0 < 20 && n < 100) begin
            s_data = words[(acc_cnt - a0 > 2) ? 2 : acc_cnt - a0];
            @(negedge prog_clk);
            n++;
        end
        checks++; if (en_cnt - en0 != 20) $display("FAIL rmid_reach20 got %0d want 20", en_cnt - en0); else passed++;
        pReset = 1'b1;
        @(negedge prog_clk);
        checks++; if (ccff_shift_en !== 1'b0) $display("FAIL rmid_shift_en got %b want 0", ccff_shift_en); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
        checks++; if (s_ready !== 1'b0) $display("FAIL rmid_s_ready got %b want 0", s_ready); else passed++;
        pReset = 1'b0;
        @(negedge prog_clk);
        checks++; if (busy !== 1'b0) $display("FAIL rmid_stays_idle busy got %b want 0", busy); else passed++;
        run_and_check("after_reset", 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_start_handling();
        run_and_check("repulse", 0, 1'b1, 1'b1, 1'b1);
        @(negedge prog_clk);
        start = 1'b1; pReset = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; pReset = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL start_reset_busy got %b want 0", busy); else passed++;
        checks++; if (ccff_shift_en !== 1'b0) $display("FAIL start_reset_shift_en got %b want 0", ccff_shift_en); else passed++;
        @(negedge prog_clk);
        checks++; if (busy !== 1'b0) $display("FAIL start_reset_busy_later got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_stall();
        test_broken_chain();
        test_reset_mid();
        test_start_handling();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
